// File: rtl/motoro3_step_sched.sv
// motoro3_step_sched: six-step commutation scheduler (align, soft-start ramp, run)
//   clk           10 MHz system clock
//   rst           synchronous active-high reset
//   run_en        level run request; dropping it stops immediately
//   start_reload  step period at ramp start (clamped to MIN_RELOAD)
//   target_reload desired step period (clamped to MIN_RELOAD), sampled at step ends
//   ramp_delta    reload change per step, sampled at step ends (0 = jump to target)
//   step_idx      commutation step 0..5
//   step_pulse    one-cycle strobe at each step boundary
//   cur_reload    step period in use
//   drive_en      phase drive enable
//   at_speed      cur_reload equals clamped target
//   state         IDLE=0, ALIGN=1, RAMP=2, RUN=3
module motoro3_step_sched #(
   parameter logic [24:0] ALIGN_CLKS = 25'd1_000_000,
   parameter logic [24:0] MIN_RELOAD = 25'd511
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_en,
   input  logic [24:0] start_reload,
   input  logic [24:0] target_reload,
   input  logic [15:0] ramp_delta,
   output logic [2:0]  step_idx,
   output logic        step_pulse,
   output logic [24:0] cur_reload,
   output logic        drive_en,
   output logic        at_speed,
   output logic [1:0]  state
);
   localparam logic [1:0] IDLE = 2'd0, ALIGN = 2'd1, RAMP = 2'd2, RUN = 2'd3;
   logic [24:0] cnt, start_c, tgt, nxt;
   logic [25:0] dn, up, dl;
   // dn/up are distances to target, so the step toward it never overshoots or wraps
   always_comb begin
      start_c = start_reload < MIN_RELOAD ? MIN_RELOAD : start_reload;
      tgt = target_reload < MIN_RELOAD ? MIN_RELOAD : target_reload;
      dl = {10'd0, ramp_delta};
      dn = {1'b0, cur_reload} - {1'b0, tgt};
      up = {1'b0, tgt} - {1'b0, cur_reload};
      nxt = ramp_delta == 16'd0 ? tgt :
            cur_reload > tgt ? (dn <= dl ? tgt : cur_reload - dl[24:0]) :
            (up <= dl ? tgt : cur_reload + dl[24:0]);
   end
   always_ff @(posedge clk) begin
      if (rst || (state != IDLE && !run_en)) begin
         state <= IDLE;
         step_idx <= 3'd0;
         step_pulse <= 1'b0;
         cur_reload <= 25'd0;
         drive_en <= 1'b0;
         at_speed <= 1'b0;
         cnt <= 25'd0;
      end else begin
         step_pulse <= 1'b0;
         if (state == IDLE) begin
            if (run_en) begin
               state <= ALIGN;
               cnt <= ALIGN_CLKS - 25'd1;
               step_idx <= 3'd0;
               drive_en <= 1'b1;
               cur_reload <= start_c;
            end
         end else if (cnt != 25'd0) begin
            cnt <= cnt - 25'd1;
         end else if (state == ALIGN) begin
            state <= RAMP;
            step_pulse <= 1'b1;
            step_idx <= 3'd1;
            cnt <= cur_reload - 25'd1;
         end else begin
            step_pulse <= 1'b1;
            step_idx <= step_idx == 3'd5 ? 3'd0 : step_idx + 3'd1;
            cur_reload <= nxt;
            cnt <= nxt - 25'd1;
            state <= nxt == tgt ? RUN : RAMP;
            at_speed <= nxt == tgt;
         end
      end
   end
endmodule

// File: tb/tb_motoro3_step_sched.sv
// tb_motoro3_step_sched: directed self-checking bench for motoro3_step_sched
module tb_motoro3_step_sched;
   logic        clk = 1'b0, rst = 1'b1, run_en = 1'b0;
   logic [24:0] start_reload = '0, target_reload = '0;
   logic [15:0] ramp_delta = '0;
   logic [2:0]  step_idx;
   logic        step_pulse, drive_en, at_speed;
   logic [24:0] cur_reload;
   logic [1:0]  state;
   int          n_cmp = 0, n_bad = 0, n;

   motoro3_step_sched #(.ALIGN_CLKS(25'd100), .MIN_RELOAD(25'd4)) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .start_reload(start_reload),
      .target_reload(target_reload), .ramp_delta(ramp_delta), .step_idx(step_idx),
      .step_pulse(step_pulse), .cur_reload(cur_reload), .drive_en(drive_en),
      .at_speed(at_speed), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // clocks until the next step_pulse sample, bounded so a dead DUT shows as a bad count
   task automatic wait_pulse(output int c);
      c = 0;
      do begin
         tick();
         c++;
      end while (!step_pulse && c < 2000);
   endtask

   function automatic logic [31:0] outs();
      return {state, step_idx, step_pulse, cur_reload, drive_en, at_speed};
   endfunction

   task automatic start(input logic [24:0] s, input logic [24:0] t, input logic [15:0] d);
      start_reload = s;
      target_reload = t;
      ramp_delta = d;
      run_en = 1'b1;
      tick();
      chk("align_state", state, 1);
      chk("align_drive", drive_en, 1);
      wait_pulse(n);
      chk("align_len", n, 100);
      chk("align_idx", step_idx, 1);
   endtask

   int exp_n[5]  = '{40, 35, 30, 25, 22};
   int exp_cr[5] = '{35, 30, 25, 22, 22};
   int exp_as[5] = '{0, 0, 0, 1, 1};

   initial begin
      // 1: reset then idle
      tick(3);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("idle_outs", outs(), 0);
      end
      // 2: align timing and steady stepping
      start(25'd20, 25'd20, 16'd5);
      chk("first_cur", cur_reload, 20);
      tick();
      chk("pulse_width", step_pulse, 0);
      wait_pulse(n);
      chk("run_per", n + 1, 20);
      chk("run_idx", step_idx, 2);
      chk("run_state", state, 3);
      chk("run_as", at_speed, 1);
      for (int i = 0; i < 5; i++) begin
         wait_pulse(n);
         chk("run_per", n, 20);
         chk("run_idx", step_idx, (i + 3) % 6);
      end
      // 3: accelerating ramp
      run_en = 1'b0;
      tick();
      chk("stop_outs", outs(), 0);
      start(25'd40, 25'd22, 16'd5);
      chk("ramp_state0", state, 2);
      for (int i = 0; i < 5; i++) begin
         wait_pulse(n);
         chk("ramp_per", n, exp_n[i]);
         chk("ramp_cur", cur_reload, exp_cr[i]);
         chk("ramp_as", at_speed, exp_as[i]);
      end
      chk("ramp_state", state, 3);
      // 5: retarget mid-step while running at 22
      tick(5);
      target_reload = 25'd30;
      wait_pulse(n);
      chk("retgt_per", n + 5, 22);
      chk("retgt_cur", cur_reload, 27);
      chk("retgt_as", at_speed, 0);
      chk("retgt_state", state, 2);
      wait_pulse(n);
      chk("retgt_per2", n, 27);
      chk("retgt_cur2", cur_reload, 30);
      chk("retgt_as2", at_speed, 1);
      wait_pulse(n);
      chk("retgt_per3", n, 30);
      // 6a: stop mid-step
      tick(7);
      run_en = 1'b0;
      tick();
      chk("stop_mid", outs(), 0);
      // 6b: stop in the cycle that would be a step end
      start(25'd20, 25'd30, 16'd5);
      tick(19);
      run_en = 1'b0;
      tick();
      chk("stop_end", outs(), 0);
      // 6c: immediate re-raise gives a full align; then stop in the pulse cycle
      start(25'd20, 25'd30, 16'd5);
      run_en = 1'b0;
      tick();
      chk("stop_pulse", outs(), 0);
      tick();
      chk("stay_idle", outs(), 0);
      // 4: clamp and zero delta
      start(25'd2, 25'd1, 16'd0);
      chk("clamp_cur", cur_reload, 4);
      for (int i = 0; i < 4; i++) begin
         wait_pulse(n);
         chk("clamp_per", n, 4);
         chk("clamp_state", state, 3);
         chk("clamp_idx", step_idx, (i + 2) % 6);
      end
      // reset mid-operation
      tick(2);
      rst = 1'b1;
      tick();
      chk("rst_mid", outs(), 0);
      rst = 1'b0;
      run_en = 1'b0;
      tick();
      chk("post_rst", outs(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
